// File: rtl/z80_bus_pkg.sv
// Shared types and defaults for the Z80 bus arbitration slice.
package z80_bus_pkg;

  localparam int unsigned DMA_MAX_BURST_DEF = 16;
  localparam int unsigned DMA_MIN_GAP_DEF   = 4;
  localparam int unsigned DMA_TIMEOUT_DEF   = 255;
  localparam int unsigned CNT_W             = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } arb_state_e;

  // A zero or oversized request falls back to the longest allowed burst.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len,
                                                 input logic [CNT_W-1:0] max_len);
    return ((len == '0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/z80_bus_dma_arbiter_counter.sv
// Loadable down counter that holds at zero; used for the release gap and REQ timeout.
module arb_down_counter
  import z80_bus_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/z80_bus_dma_arbiter.sv
// Z80 BUSRQ/BUSAK arbiter granting a secondary master bounded bursts with a CPU gap.
// Define ARB_TIMEOUT_EN to abort a request the CPU never acknowledges.
module z80_bus_dma_arbiter
  import z80_bus_pkg::*;
#(
  parameter int unsigned MAX_BURST = DMA_MAX_BURST_DEF,
  parameter int unsigned MIN_GAP   = DMA_MIN_GAP_DEF,
  parameter int unsigned TIMEOUT   = DMA_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             busrq_n_o,
  input  logic             busak_n_i,
  input  logic             dma_req_i,
  input  logic [CNT_W-1:0] dma_len_i,
  input  logic             dma_beat_i,
  output logic             dma_gnt_o,
  output logic             dma_done_o,
  output logic             dma_err_o,
  output logic [CNT_W-1:0] dma_count_o
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busrq_n_q, busrq_n_d;
  logic             gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             gap_load, gap_dec;
  logic [CNT_W-1:0] gap_cnt;

  arb_down_counter #(.W(CNT_W)) u_gap_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (gap_load),
    .load_val_i (CNT_W'(MIN_GAP)),
    .dec_i      (gap_dec),
    .count_o    (gap_cnt)
  );

`ifdef ARB_TIMEOUT_EN
  logic             tmo_load, tmo_dec;
  logic [CNT_W-1:0] tmo_cnt;

  // Loaded with TIMEOUT-1 so an unanswered request lasts exactly TIMEOUT cycles.
  arb_down_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmo_load),
    .load_val_i (CNT_W'(TIMEOUT - 1)),
    .dec_i      (tmo_dec),
    .count_o    (tmo_cnt)
  );
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^CNT_W'(TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gap_dec = 1'b1;
        if (dma_req_i && (gap_cnt == '0)) begin
          state_d = REQ;
          len_d   = clamp_len(dma_len_i, CNT_W'(MAX_BURST));
          count_d = '0;
`ifdef ARB_TIMEOUT_EN
          tmo_load = 1'b1;
`endif
        end
      end
      REQ: begin
        if (!busak_n_i) begin
          state_d = GRANT;
        end else if (!dma_req_i) begin
          state_d = RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_cnt == '0) begin
          state_d = RELEASE;
          err_d   = 1'b1;
        end else begin
          tmo_dec = 1'b1;
`endif
        end
      end
      GRANT: begin
        // A beat on the exit cycle still counts.
        if (dma_beat_i) begin
          count_d = count_q + CNT_W'(1);
        end
        if ((count_d >= len_q) || !dma_req_i) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (busak_n_i) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          gap_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busrq_n_d = !((state_d == REQ) || (state_d == GRANT));
    gnt_d     = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      busrq_n_q <= 1'b1;
      gnt_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      busrq_n_q <= busrq_n_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busrq_n_o   = busrq_n_q;
  assign dma_gnt_o   = gnt_q;
  assign dma_done_o  = done_q;
  assign dma_err_o   = err_q;
  assign dma_count_o = count_q;

endmodule

// File: tb/tb_z80_bus_dma_arbiter.sv
// Randomized scoreboard bench for z80_bus_dma_arbiter with a behavioural CPU/DMA model.
module tb_z80_bus_dma_arbiter;

  localparam int MAXB = 16;
  localparam int GAP  = 4;
  localparam int TMO  = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busrq_n, busak_n;
  logic       dma_req, dma_beat;
  logic [7:0] dma_len;
  logic       dma_gnt, dma_done, dma_err;
  logic [7:0] dma_count;

  z80_bus_dma_arbiter #(.MAX_BURST(MAXB), .MIN_GAP(GAP), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .busrq_n_o   (busrq_n),
    .busak_n_i   (busak_n),
    .dma_req_i   (dma_req),
    .dma_len_i   (dma_len),
    .dma_beat_i  (dma_beat),
    .dma_gnt_o   (dma_gnt),
    .dma_done_o  (dma_done),
    .dma_err_o   (dma_err),
    .dma_count_o (dma_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int beats;
    bit gnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input int l);
    return ((l == 0) || (l > MAXB)) ? MAXB : l;
  endfunction

  // CPU model: acknowledges cpu_delay clocks after BUSRQ, releases rel_delay after it drops.
  int cpu_delay = 2;
  int rel_delay = 1;
  bit force_ack = 1'b0;
  int lo_cnt = 0;
  int hi_cnt = 0;

  initial begin
    busak_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        lo_cnt  = 0;
        hi_cnt  = 0;
        busak_n = 1'b1;
      end else begin
        if (!busrq_n) begin
          lo_cnt++;
          hi_cnt = 0;
        end else begin
          hi_cnt++;
          lo_cnt = 0;
        end
        if (force_ack) busak_n = 1'b0;
        else if (lo_cnt > cpu_delay) busak_n = 1'b0;
        else if (hi_cnt >= rel_delay) busak_n = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each done pulse and checks protocol timing.
  bit gnt_seen = 1'b0;
  bit ack_pend = 1'b0;
  bit gap_track = 1'b0;
  int gap_cycles = 0;
  int err_pulses = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      gnt_seen   = 1'b0;
      ack_pend   = 1'b0;
      gap_track  = 1'b0;
      gap_cycles = 0;
    end else begin
      if (ack_pend) chk("grant_latency", int'(dma_gnt), 1);
      ack_pend = !busrq_n && !busak_n && !dma_gnt;
      if (dma_gnt) begin
        gnt_seen = 1'b1;
        chk("gnt_holds_busrq", int'(busrq_n), 0);
      end
      if (dma_err) err_pulses++;
      if (gap_track) begin
        if (!busrq_n) begin
          chk("cpu_gap", (gap_cycles >= GAP) ? GAP : gap_cycles, GAP);
          gap_track = 1'b0;
        end else if (busak_n) begin
          gap_cycles++;
        end
      end
      if (dma_done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("burst_count", int'(dma_count), e.beats);
          chk("burst_granted", int'(gnt_seen), int'(e.gnt));
        end
        gnt_seen   = 1'b0;
        gap_track  = 1'b1;
        gap_cycles = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(busrq_n && busak_n) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_wait_expired", 0, 1);
    repeat (GAP + 4) @(posedge clk);
  endtask

  task automatic raise_req(input int len);
    @(posedge clk);
    #1;
    dma_len  = 8'(len);
    dma_req  = 1'b1;
    dma_beat = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk("busrq_latency", int'(busrq_n), 0);
  endtask

  // One burst; optionally withdraws dma_req after a random number of beats.
  task automatic do_burst(input int len, input bit wd_en, input int pct);
    int eff = clamp_len(len);
    int wd_at = -1;
    bit wd_beat = 1'b0;
    int issued = 0;
    int cyc = 0;
    bit last = 1'b0;
    bit fin = 1'b0;
    if (wd_en) begin
      wd_at   = int'($urandom_range(eff - 1, 0));
      wd_beat = 1'($urandom);
    end
    sb.push_back('{beats: wd_en ? wd_at + int'(wd_beat) : eff, gnt: 1'b1});
    raise_req(len);
    while (!fin && (cyc < 300)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (last) begin
        dma_req  = 1'b0;
        dma_beat = 1'b0;
        fin      = 1'b1;
      end else if (dma_gnt) begin
        if (issued == wd_at) begin
          dma_req  = 1'b0;
          dma_beat = wd_beat;
          last     = 1'b1;
        end else if (int'($urandom_range(99, 0)) < pct) begin
          dma_beat = 1'b1;
          issued++;
          if (issued == eff) last = 1'b1;
        end else begin
          dma_beat = 1'b0;
        end
      end else begin
        dma_beat = 1'($urandom);
      end
    end
    if (!fin) begin
      chk("burst_cycle_budget", 0, 1);
      dma_req  = 1'b0;
      dma_beat = 1'b0;
    end
    wait_idle();
  endtask

  // dma_req held high across several back-to-back bursts.
  task automatic held_bursts(input int len, input int nb);
    int eff = clamp_len(len);
    int total = 0;
    int cyc = 0;
    bit last = 1'b0;
    bit fin = 1'b0;
    for (int i = 0; i < nb; i++) sb.push_back('{beats: eff, gnt: 1'b1});
    raise_req(len);
    while (!fin && (cyc < 600)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (last) begin
        dma_req  = 1'b0;
        dma_beat = 1'b0;
        fin      = 1'b1;
      end else if (dma_gnt) begin
        dma_beat = 1'b1;
        total++;
        if (total == nb * eff) last = 1'b1;
      end else begin
        dma_beat = 1'b0;
      end
    end
    if (!fin) begin
      chk("held_cycle_budget", 0, 1);
      dma_req  = 1'b0;
      dma_beat = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    reset_n  = 1'b1;
    dma_req  = 1'b0;
    dma_beat = 1'b0;
    dma_len  = 8'd0;
    #3 reset_n = 1'b0;
    #9;
    chk("reset_busrq_n", int'(busrq_n), 1);
    chk("reset_gnt", int'(dma_gnt), 0);
    chk("reset_done", int'(dma_done), 0);
    chk("reset_err", int'(dma_err), 0);
    chk("reset_count", int'(dma_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    cpu_delay = 2;
    rel_delay = 1;
    do_burst(3, 1'b0, 100);
    do_burst(0, 1'b0, 100);
    do_burst(200, 1'b0, 70);
    held_bursts(6, 3);

    // Withdraw while still waiting for BUSAK.
    cpu_delay = 8;
    sb.push_back('{beats: 0, gnt: 1'b0});
    raise_req(5);
    repeat (2) @(posedge clk);
    #1 dma_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("withdraw_busrq_n", int'(busrq_n), 1);
    wait_idle();
    cpu_delay = 2;

    // BUSAK asserted while idle must not produce a grant.
    @(posedge clk);
    #1 force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_no_gnt", int'(dma_gnt), 0);
      chk("idle_ack_busrq_n", int'(busrq_n), 1);
    end
    force_ack = 1'b0;
    wait_idle();

    // CPU never acknowledges.
    cpu_delay = 100000;
    sb.push_back('{beats: 0, gnt: 1'b0});
`ifdef ARB_TIMEOUT_EN
    @(posedge clk);
    #1;
    dma_len = 8'd4;
    dma_req = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && (n < 30)) begin
      @(negedge clk);
      n++;
      if (dma_err) got = 1'b1;
    end
    chk("timeout_err_seen", int'(got), 1);
    chk("timeout_err_cycle", n, TMO + 2);
    chk("timeout_busrq_n", int'(busrq_n), 1);
    @(posedge clk);
    #1 dma_req = 1'b0;
`else
    raise_req(4);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busrq_n) n++;
    end
    chk("no_timeout_busrq_low", n, 300);
    @(posedge clk);
    #1 dma_req = 1'b0;
`endif
    wait_idle();
    cpu_delay = 2;

    for (int t = 0; t < 25; t++) begin
      int len;
      cpu_delay = int'($urandom_range(3, 1));
      rel_delay = int'($urandom_range(3, 1));
      len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 17)) : int'($urandom_range(16, 0));
      do_burst(len, ($urandom_range(3, 0) == 0), int'($urandom_range(100, 30)));
    end

    chk("scoreboard_drained", sb.size(), 0);
`ifdef ARB_TIMEOUT_EN
    chk("err_pulse_total", err_pulses, 1);
`else
    chk("err_pulse_total", err_pulses, 0);
`endif

    // Asynchronous reset in the middle of a granted burst.
    cpu_delay = 2;
    rel_delay = 1;
    @(posedge clk);
    #1;
    dma_len  = 8'd5;
    dma_req  = 1'b1;
    dma_beat = 1'b0;
    n = 0;
    while (!dma_gnt && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reset_test_granted", int'(dma_gnt), 1);
    dma_beat = 1'b1;
    @(posedge clk);
    #1 dma_beat = 1'b1;
    @(posedge clk);
    #1 dma_beat = 1'b0;
    chk("count_before_reset", int'(dma_count), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_busrq_n", int'(busrq_n), 1);
    chk("midreset_gnt", int'(dma_gnt), 0);
    chk("midreset_count", int'(dma_count), 0);
    chk("midreset_done", int'(dma_done), 0);
    dma_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
